// File: rtl/ysyx22041405_wb_sched.sv
// Write-back scheduler: round-robin arbitration of EXU/LSU onto the RF write port plus busy scoreboard.
// Optional YSYX22041405_WB_CONFLICT_CNT_EN adds a counter of cycles where both sources request.
module ysyx22041405_wb_sched #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned REGNUM = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb0_valid,
    output logic             wb0_ready,
    input  logic [4:0]       wb0_rd,
    input  logic [WIDTH-1:0] wb0_data,
    input  logic             wb1_valid,
    output logic             wb1_ready,
    input  logic [4:0]       wb1_rd,
    input  logic [WIDTH-1:0] wb1_data,
    input  logic             iss_valid,
    input  logic [4:0]       iss_rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    output logic             stall,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
`ifdef YSYX22041405_WB_CONFLICT_CNT_EN
    output logic [31:0]      conflict_cnt,
`endif
    output logic [WIDTH-1:0] rf_wdata
);

    logic              rr_q, rr_d;
    logic [REGNUM-1:0] busy_q, busy_d;
    logic              we_q;
    logic [4:0]        waddr_q;
    logic [WIDTH-1:0]  wdata_q;

    logic              grant0, grant1, both, acc, wr;
    logic [4:0]        sel_rd;
    logic [WIDTH-1:0]  sel_data;
    logic              issue;

    // rr_q == 0 prefers EXU when both sources request
    always_comb begin
        both      = wb0_valid && wb1_valid;
        grant0    = wb0_valid && (!wb1_valid || !rr_q);
        grant1    = wb1_valid && (!wb0_valid || rr_q);
        wb0_ready = grant0;
        wb1_ready = grant1;
        acc       = grant0 || grant1;
        sel_rd    = grant1 ? wb1_rd : wb0_rd;
        sel_data  = grant1 ? wb1_data : wb0_data;
        wr        = acc && (sel_rd != 5'd0);
        rr_d      = both ? !rr_q : rr_q;
    end

    always_comb begin
        stall = iss_valid && (busy_q[rs1] || busy_q[rs2] || busy_q[iss_rd]);
        issue = iss_valid && !stall && (iss_rd != 5'd0);
    end

    // Clear first so a same-edge issue to the same register keeps it busy
    always_comb begin
        busy_d = busy_q;
        if (wr) begin
            busy_d[sel_rd] = 1'b0;
        end
        if (issue) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q    <= 1'b0;
            busy_q  <= '0;
            we_q    <= 1'b0;
            waddr_q <= 5'd0;
            wdata_q <= '0;
        end else begin
            rr_q   <= rr_d;
            busy_q <= busy_d;
            we_q   <= wr;
            if (wr) begin
                waddr_q <= sel_rd;
                wdata_q <= sel_data;
            end
        end
    end

    assign rf_we    = we_q;
    assign rf_waddr = waddr_q;
    assign rf_wdata = wdata_q;

`ifdef YSYX22041405_WB_CONFLICT_CNT_EN
    logic [31:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 32'd0;
        end else if (both) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign conflict_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_ysyx22041405_wb_sched.sv
// Scoreboard bench for ysyx22041405_wb_sched: expected RF writes queued at handshake, compared at output.
module tb_ysyx22041405_wb_sched;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb0_valid = 1'b0, wb1_valid = 1'b0;
    logic        wb0_ready, wb1_ready;
    logic [4:0]  wb0_rd = '0, wb1_rd = '0;
    logic [31:0] wb0_data = '0, wb1_data = '0;
    logic        iss_valid = 1'b0;
    logic [4:0]  iss_rd = '0, rs1 = '0, rs2 = '0;
    logic        stall;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
`ifdef YSYX22041405_WB_CONFLICT_CNT_EN
    logic [31:0] conflict_cnt;
`endif

    ysyx22041405_wb_sched #(.WIDTH(32), .REGNUM(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .wb0_valid (wb0_valid),
        .wb0_ready (wb0_ready),
        .wb0_rd    (wb0_rd),
        .wb0_data  (wb0_data),
        .wb1_valid (wb1_valid),
        .wb1_ready (wb1_ready),
        .wb1_rd    (wb1_rd),
        .wb1_data  (wb1_data),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .stall     (stall),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
`ifdef YSYX22041405_WB_CONFLICT_CNT_EN
        .conflict_cnt (conflict_cnt),
`endif
        .rf_wdata  (rf_wdata)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    wb_t         exp_q[$];
    logic [31:0] busy_m = '0;
    logic        rr_m = 1'b0;
    logic [4:0]  last_addr = '0;
    logic [31:0] last_data = '0;
    logic [31:0] cnt_m = '0;
    logic        obs_g0, obs_g1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One cycle: starts and ends at a negedge with inputs already driven
    task automatic step();
        logic g0, g1, exp_stall;
        wb_t  e;
        #1;
        g0 = wb0_valid && (!wb1_valid || !rr_m);
        g1 = wb1_valid && (!wb0_valid || rr_m);
        exp_stall = iss_valid && (busy_m[rs1] || busy_m[rs2] || busy_m[iss_rd]);
        check_eq("wb0_ready", 32'(wb0_ready), 32'(g0));
        check_eq("wb1_ready", 32'(wb1_ready), 32'(g1));
        check_eq("stall", 32'(stall), 32'(exp_stall));
        obs_g0 = wb0_ready;
        obs_g1 = wb1_ready;
        if (g0 || g1) begin
            e.rd   = g1 ? wb1_rd : wb0_rd;
            e.data = g1 ? wb1_data : wb0_data;
            if (e.rd != 5'd0) begin
                exp_q.push_back(e);
                busy_m[e.rd] = 1'b0;
            end
        end
        if (iss_valid && !exp_stall && iss_rd != 5'd0) busy_m[iss_rd] = 1'b1;
        if (wb0_valid && wb1_valid) begin
            rr_m  = !rr_m;
            cnt_m = cnt_m + 32'd1;
        end
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("rf_we", 32'(rf_we), 32'd1);
            check_eq("rf_waddr", 32'(rf_waddr), 32'(e.rd));
            check_eq("rf_wdata", rf_wdata, e.data);
            last_addr = e.rd;
            last_data = e.data;
        end else begin
            check_eq("rf_we_idle", 32'(rf_we), 32'd0);
            check_eq("rf_waddr_hold", 32'(rf_waddr), 32'(last_addr));
            check_eq("rf_wdata_hold", rf_wdata, last_data);
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        wb0_valid = 1'b0;
        wb1_valid = 1'b0;
        iss_valid = 1'b0;
        iss_rd    = '0;
        rs1       = '0;
        rs2       = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0]  r0 [3];
        logic [4:0]  r1 [2];
        logic [31:0] d0 [3];
        logic [31:0] d1 [2];
        int          i0, i1, n;
        int          order [5];
        int          exp_order [5];

        // Reset values
        #1;
        check_eq("rst_rf_we", 32'(rf_we), 32'd0);
        check_eq("rst_rf_waddr", 32'(rf_waddr), 32'd0);
        check_eq("rst_rf_wdata", rf_wdata, 32'd0);
        check_eq("rst_ready0", 32'(wb0_ready), 32'd0);
        check_eq("rst_stall", 32'(stall), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Single request
        wb0_valid = 1'b1; wb0_rd = 5'd5; wb0_data = 32'hDEADBEEF;
        step();
        idle_inputs();
        step();

        // Contention: grant order 0,1,0,1 then EXU drains alone
        r0 = '{5'd1, 5'd3, 5'd5};
        r1 = '{5'd2, 5'd4};
        for (int k = 0; k < 3; k++) d0[k] = $urandom;
        for (int k = 0; k < 2; k++) d1[k] = $urandom;
        exp_order = '{0, 1, 0, 1, 0};
        i0 = 0; i1 = 0; n = 0;
        while ((i0 < 3 || i1 < 2) && n < 5) begin
            wb0_valid = (i0 < 3);
            wb0_rd    = (i0 < 3) ? r0[i0] : 5'd0;
            wb0_data  = (i0 < 3) ? d0[i0] : 32'd0;
            wb1_valid = (i1 < 2);
            wb1_rd    = (i1 < 2) ? r1[i1] : 5'd0;
            wb1_data  = (i1 < 2) ? d1[i1] : 32'd0;
            step();
            order[n] = obs_g1 ? 1 : (obs_g0 ? 0 : 2);
            check_eq("grant_order", 32'(order[n]), 32'(exp_order[n]));
            if (obs_g0) i0++;
            if (obs_g1) i1++;
            n++;
        end
        check_eq("contention_drained", 32'(i0 + i1), 32'd5);
        idle_inputs();
        step();

        // Scoreboard RAW: issue rd7, then read rs1=7 while LSU writes rd7
        iss_valid = 1'b1; iss_rd = 5'd7;
        step();
        iss_rd = 5'd10; rs1 = 5'd7;
        wb1_valid = 1'b1; wb1_rd = 5'd7; wb1_data = 32'h0000_7777;
        step();
        wb1_valid = 1'b0;
        step();
        idle_inputs();

        // Same-edge set and clear of rd9: set wins
        iss_valid = 1'b1; iss_rd = 5'd9;
        wb0_valid = 1'b1; wb0_rd = 5'd9; wb0_data = 32'h9999_0009;
        step();
        wb0_valid = 1'b0;
        iss_rd = 5'd11; rs2 = 5'd9;
        step();
        idle_inputs();

        // rd0 write-back and x0 never busy
        wb1_valid = 1'b1; wb1_rd = 5'd0; wb1_data = 32'hFFFF_0000;
        iss_valid = 1'b1; iss_rd = 5'd0;
        step();
        wb1_valid = 1'b0;
        rs1 = 5'd0; iss_rd = 5'd12;
        step();
        idle_inputs();

        // Conflict counter scenario: 3 both-valid cycles then 2 single-valid cycles
        for (int k = 0; k < 3; k++) begin
            wb0_valid = 1'b1; wb0_rd = 5'd20 + 5'(k); wb0_data = $urandom;
            wb1_valid = 1'b1; wb1_rd = 5'd24 + 5'(k); wb1_data = $urandom;
            step();
        end
        wb1_valid = 1'b0;
        step();
        wb0_valid = 1'b0; wb1_valid = 1'b1;
        step();
        idle_inputs();
        step();
`ifdef YSYX22041405_WB_CONFLICT_CNT_EN
        check_eq("conflict_cnt", conflict_cnt, cnt_m);
`endif

        // Reset mid-write: leave rr pointing at LSU and rf_we high, with rd13 busy
        wb0_valid = 1'b1; wb0_rd = 5'd14; wb0_data = 32'h1414_1414;
        wb1_valid = 1'b1; wb1_rd = 5'd15; wb1_data = 32'h1515_1515;
        iss_valid = 1'b1; iss_rd = 5'd13;
        step();
        if (!rr_m) step();
        wb0_valid = 1'b0; wb1_valid = 1'b0;
        iss_valid = 1'b1; iss_rd = 5'd0; rs1 = 5'd13;
        rst = 1'b1;
        #1;
        check_eq("rst_async_we", 32'(rf_we), 32'd0);
        check_eq("rst_async_waddr", 32'(rf_waddr), 32'd0);
        check_eq("rst_busy_clear", 32'(stall), 32'd0);
`ifdef YSYX22041405_WB_CONFLICT_CNT_EN
        check_eq("rst_conflict_cnt", conflict_cnt, 32'd0);
`endif
        busy_m = '0; rr_m = 1'b0; cnt_m = '0;
        last_addr = '0; last_data = '0;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        wb0_valid = 1'b1; wb0_rd = 5'd16; wb0_data = 32'h1616_1616;
        wb1_valid = 1'b1; wb1_rd = 5'd17; wb1_data = 32'h1717_1717;
        step();
        check_eq("post_rst_grant0", 32'(obs_g0), 32'd1);
        wb0_valid = 1'b0;
        step();
        idle_inputs();
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
